galpal_22v10_fuse_loader: RTL and testbench

- Writer side of the 22V10 fuse map. Accepts a serial JEDEC-order fuse bit stream (fuse 0 first) over a valid/ready handshake.
- Assembles the 5892-bit fuse vector and computes the JEDEC 16-bit fuse checksum on the fly.
- Sits between a host/programming front end and anything that consumes a 22V10 fuse vector.

---
 rtl/galpal_22v10_fuse_loader.sv | 111 +++++++++++
 tb/tb_galpal_22v10_fuse_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/galpal_22v10_fuse_loader.sv
// 22V10 fuse-map writer: serial JEDEC-order bit stream in, 5892-bit fuse vector and JEDEC checksum out.
// Optional reader side (serial fuse readback) enabled by defining GALPAL_FUSE_READBACK_EN.
module galpal_22v10_fuse_loader #(
  parameter int FUSES  = 5892,
  parameter int ADDR_W = 13
) (
  input  logic              CLK,
  input  logic              _RST,
  input  logic              CLR,
  input  logic              DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              DONE,
  output logic              ERR,
  output logic [ADDR_W-1:0] ADDR,
  output logic [FUSES-1:0]  FUSE,
  output logic [15:0]       CSUM
`ifdef GALPAL_FUSE_READBACK_EN
  ,
  input  logic              RD_START,
  output logic              DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t      state, state_nxt;
  logic [7:0]  acc;
  logic [7:0]  byte_nxt;
  logic        accept;
  logic        last_fuse;
  logic        byte_end;

  function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] b);
    return sum + {8'h00, b};
  endfunction

  assign DIN_READY = (state != FULL);
  assign DONE      = (state == FULL);
  assign accept    = DIN_VALID && DIN_READY && !CLR;
  assign last_fuse = (ADDR == ADDR_W'(FUSES - 1));
  // The short final byte closes early on the last fuse; its upper bits stay zero.
  assign byte_end  = (ADDR[2:0] == 3'd7) || last_fuse;
  assign byte_nxt  = acc | ({7'd0, DIN} << ADDR[2:0]);

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (CLR)         state_nxt = IDLE;
    else if (accept) state_nxt = last_fuse ? FULL : LOAD;
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      FUSE <= '0;
      ADDR <= '0;
      CSUM <= '0;
      acc  <= '0;
      ERR  <= 1'b0;
    end else if (CLR) begin
      // FUSE is deliberately kept; the next load overwrites every bit.
      ADDR <= '0;
      CSUM <= '0;
      acc  <= '0;
      ERR  <= 1'b0;
    end else begin
      if (accept) begin
        FUSE[ADDR] <= DIN;
        ADDR       <= ADDR + ADDR_W'(1);
        if (byte_end) begin
          CSUM <= csum_add(CSUM, byte_nxt);
          acc  <= '0;
        end else begin
          acc  <= byte_nxt;
        end
      end
      if ((state == FULL) && DIN_VALID) ERR <= 1'b1;
    end
  end

`ifdef GALPAL_FUSE_READBACK_EN
  logic              rd_active;
  logic [ADDR_W-1:0] rd_addr;

  assign DOUT       = FUSE[rd_addr];
  assign DOUT_VALID = rd_active;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      rd_active <= 1'b0;
      rd_addr   <= '0;
    end else if (CLR) begin
      rd_active <= 1'b0;
      rd_addr   <= '0;
    end else if (RD_START && DONE) begin
      rd_active <= 1'b1;
      rd_addr   <= '0;
    end else if (rd_active && DOUT_READY) begin
      if (rd_addr == ADDR_W'(FUSES - 1)) rd_active <= 1'b0;
      else                               rd_addr   <= rd_addr + ADDR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_galpal_22v10_fuse_loader.sv
// Scoreboard bench for galpal_22v10_fuse_loader: completion records and readback bits are queued
// by the stimulus and checked by a monitor when the DUT raises DONE or presents DOUT.
module tb_galpal_22v10_fuse_loader;
  localparam int FUSES  = 5892;
  localparam int ADDR_W = 13;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              din;
  logic              din_valid;
  logic              din_ready;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] addr;
  logic [FUSES-1:0]  fuse;
  logic [15:0]       csum;
`ifdef GALPAL_FUSE_READBACK_EN
  logic              rd_start;
  logic              dout;
  logic              dout_valid;
  logic              dout_ready;
`endif

  galpal_22v10_fuse_loader #(.FUSES(FUSES), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), ._RST(rst_n), .CLR(clr), .DIN(din), .DIN_VALID(din_valid),
    .DIN_READY(din_ready), .DONE(done), .ERR(err), .ADDR(addr), .FUSE(fuse), .CSUM(csum)
`ifdef GALPAL_FUSE_READBACK_EN
    , .RD_START(rd_start), .DOUT(dout), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready)
`endif
  );

  typedef struct {
    logic [15:0]      csum;
    logic [FUSES-1:0] fuse;
  } done_t;

  done_t exp_q[$];
  bit    rd_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_fuse(input string name, input logic [FUSES-1:0] exp);
    int nbad;
    int first;
    nbad  = 0;
    first = -1;
    n_vec++;
    for (int i = 0; i < FUSES; i++)
      if (fuse[i] !== exp[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    if (nbad != 0) begin
      n_err++;
      $display("FAIL %s: %0d fuse bits differ, first at %0d (got %b, expected %b)",
               name, nbad, first, fuse[first], exp[first]);
    end
  endtask

  // Monitor: consumes one completion record per DONE rise, one bit per readback handshake.
  initial begin
    logic  done_q;
    done_t rec;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          rec = exp_q.pop_front();
          check("done_csum", csum, rec.csum);
          check("done_addr", addr, FUSES);
          check("done_err", err, 0);
          check_fuse("done_fuse", rec.fuse);
        end
      end
      done_q = done;
`ifdef GALPAL_FUSE_READBACK_EN
      if (dout_valid && dout_ready) begin
        if (rd_q.size() == 0) check("dout_unexpected", 1, 0);
        else                  check("dout_bit", dout, rd_q.pop_front());
      end
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    done_t            rec;
    logic [15:0]      pat;
    logic [FUSES-1:0] ones;
    ones = '1;
    rst_n = 1'b0; clr = 1'b0; din = 1'b0; din_valid = 1'b0;
`ifdef GALPAL_FUSE_READBACK_EN
    rd_start = 1'b0; dout_ready = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", din_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", addr, 0);
    check("rst_csum", csum, 16'h0000);
    check_fuse("rst_fuse", '0);

    // All ones, back-to-back
    rec.csum = 16'hDD2F;
    rec.fuse = ones;
    exp_q.push_back(rec);
    for (int i = 0; i < FUSES; i++) begin
      @(negedge clk);
      if (i == FUSES - 1) check("done_early", done, 0);
      din_valid = 1'b1;
      din       = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    check("done_latency", done, 1);
    check("full_ready", din_ready, 0);
    @(negedge clk);
    check("ones_drain", exp_q.size(), 0);

    // Overrun, then clear
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    check("ovr_err", err, 1);
    check("ovr_csum", csum, 16'hDD2F);
    check("ovr_addr", addr, FUSES);
    check_fuse("ovr_fuse", ones);
    @(negedge clk);
    check("ovr_sticky", err, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_err", err, 0);
    check("clr_done", done, 0);
    check("clr_addr", addr, 0);
    check("clr_ready", din_ready, 1);
    check("clr_csum", csum, 0);

    // Sparse pattern with valid gaps
    rec.csum = 16'h0088;
    rec.fuse = '0;
    rec.fuse[7] = 1'b1;
    rec.fuse[FUSES-1] = 1'b1;
    exp_q.push_back(rec);
    for (int i = 0; i < FUSES; i++) begin
      @(negedge clk);
      if (i == 10) check("gap_addr10", addr, 10);
      if (i == 11) check("gap_addr11", addr, 11);
      din_valid = 1'b1;
      din       = (i == 7) || (i == FUSES - 1);
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'b0;
    end
    check("gap_done", done, 1);
    @(negedge clk);
    check("gap_drain", exp_q.size(), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // Byte packing order: 0xA5 then 0x3C, LSB first
    pat = 16'h3CA5;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din       = pat[i];
    end
    @(negedge clk);
    din_valid = 1'b0;
    check("pack_csum", csum, 16'h00E1);
    check("pack_addr", addr, 16);
    check("pack_fuse", fuse[15:0], 16'h3CA5);

    // CLR with a valid bit at ADDR=100
    for (int i = 16; i < 100; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din       = 1'b1;
    end
    @(negedge clk);
    check("pre_clr_addr", addr, 100);
    clr = 1'b1;
    din = 1'b1;
    @(negedge clk);
    clr       = 1'b0;
    din_valid = 1'b0;
    check("clrv_addr", addr, 0);
    check("clrv_dropped", fuse[100], 0);
    check("clrv_csum", csum, 0);
    check("clrv_ready", din_ready, 1);

    // Asynchronous reset mid-load at ADDR=50
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din       = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    check("pre_rst_addr", addr, 50);
    #2 rst_n = 1'b0;
    #1;
    check("arst_addr", addr, 0);
    check("arst_csum", csum, 0);
    check("arst_done", done, 0);
    check("arst_err", err, 0);
    check("arst_ready", din_ready, 1);
    check_fuse("arst_fuse", '0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef GALPAL_FUSE_READBACK_EN
    @(negedge clk);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("rd_ignored0", dout_valid, 0);
    @(negedge clk);
    check("rd_ignored1", dout_valid, 0);

    rec.csum = 16'hE8CA;
    for (int n = 0; n < FUSES; n++) rec.fuse[n] = n[0];
    exp_q.push_back(rec);
    for (int n = 0; n < FUSES; n++) begin
      @(negedge clk);
      din_valid = 1'b1;
      din       = n[0];
    end
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    check("alt_drain", exp_q.size(), 0);

    for (int n = 0; n < FUSES; n++) rd_q.push_back(n[0]);
    dout_ready = 1'b1;
    rd_start   = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("rd_valid", dout_valid, 1);
    check("rd_block_load", din_ready, 0);
    for (int k = 0; k < 6000 && dout_valid; k++) @(negedge clk);
    check("rd_drain", rd_q.size(), 0);
    check("rd_end", dout_valid, 0);
    @(negedge clk);
    check("rd_end_hold", dout_valid, 0);
`endif

    repeat (2) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
